// File: rtl/box_centroid.sv
// Per-frame centroid of matched in-box capture pixels, computed with a serial restoring divider.
// Define BOX_CENTROID_EXTENT_EN to add the bounding-extent outputs ext_min_x/ext_max_x/ext_min_y/ext_max_y.
module box_centroid #(
  parameter int MIN_COUNT = 16,
  parameter int ACC_W     = 28,
  parameter int CNT_W     = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [9:0]       capture_x,
  input  logic [9:0]       capture_y,
  input  logic             capture_in_box,
  input  logic             pix_match,
  input  logic             frame_end,
  output logic [9:0]       centroid_x,
  output logic [9:0]       centroid_y,
  output logic [CNT_W-1:0] pix_count,
  output logic             target_found,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
`ifdef BOX_CENTROID_EXTENT_EN
  ,
  output logic [9:0]       ext_min_x,
  output logic [9:0]       ext_max_x,
  output logic [9:0]       ext_min_y,
  output logic [9:0]       ext_max_y
`endif
);

  localparam int STEP_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt, snap_cnt;
  logic [ACC_W-1:0]  sx, sy, snap_sy;
  logic [CNT_W-1:0]  cnt_nx;
  logic [ACC_W-1:0]  sx_nx, sy_nx;
  logic [CNT_W:0]    cnt_sum;
  logic [ACC_W:0]    sx_sum, sy_sum;
  logic              qual, found_nx;

  logic [ACC_W-1:0]  dvd, dvd_next;
  logic [CNT_W-1:0]  rem, rem_next;
  logic [CNT_W:0]    trial, diff;
  logic              ge;
  logic [STEP_W-1:0] step;
  logic [9:0]        quot_x;

  // Next-frame accumulator values include the pixel of the current cycle, so a
  // frame_end snapshot sees a coincident qualifying pixel.
  assign qual    = pix_valid && capture_in_box && pix_match;
  assign cnt_sum = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign sx_sum  = {1'b0, sx} + {{(ACC_W-9){1'b0}}, capture_x};
  assign sy_sum  = {1'b0, sy} + {{(ACC_W-9){1'b0}}, capture_y};
  assign cnt_nx  = !qual ? cnt : (cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0]);
  assign sx_nx   = !qual ? sx  : (sx_sum[ACC_W]  ? '1 : sx_sum[ACC_W-1:0]);
  assign sy_nx   = !qual ? sy  : (sy_sum[ACC_W]  ? '1 : sy_sum[ACC_W-1:0]);
  assign found_nx = cnt_nx >= CNT_W'(MIN_COUNT);

  // Remainder stays below the divisor, so the borrow bit of diff is the compare result.
  assign trial    = {rem, dvd[ACC_W-1]};
  assign diff     = trial - {1'b0, snap_cnt};
  assign ge       = ~diff[CNT_W];
  assign rem_next = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
  assign dvd_next = {dvd[ACC_W-2:0], ge};

`ifdef BOX_CENTROID_EXTENT_EN
  logic [9:0] run_min_x, run_max_x, run_min_y, run_max_y;
  logic [9:0] mnx_nx, mxx_nx, mny_nx, mxy_nx;
  logic [9:0] snap_mnx, snap_mxx, snap_mny, snap_mxy;

  assign mnx_nx = (qual && capture_x < run_min_x) ? capture_x : run_min_x;
  assign mxx_nx = (qual && capture_x > run_max_x) ? capture_x : run_max_x;
  assign mny_nx = (qual && capture_y < run_min_y) ? capture_y : run_min_y;
  assign mxy_nx = (qual && capture_y > run_max_y) ? capture_y : run_max_y;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // DIV_Y spends its first cycle loading the y dividend, which gives the 2*ACC_W+1 latency.
  always_comb begin
    state_nx     = state;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE:  if (frame_end) state_nx = found_nx ? DIV_X : DONE;
      DIV_X: begin
        busy = 1'b1;
        if (step == STEP_W'(ACC_W - 1)) state_nx = DIV_Y;
      end
      DIV_Y: begin
        busy = 1'b1;
        if (step == STEP_W'(ACC_W)) state_nx = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0; sx <= '0; sy <= '0;
      snap_cnt <= '0; snap_sy <= '0;
      dvd <= '0; rem <= '0; step <= '0; quot_x <= '0;
      centroid_x <= '0; centroid_y <= '0; pix_count <= '0;
      target_found <= 1'b0; overrun <= 1'b0;
`ifdef BOX_CENTROID_EXTENT_EN
      run_min_x <= 10'h3FF; run_max_x <= '0; run_min_y <= 10'h3FF; run_max_y <= '0;
      snap_mnx <= 10'h3FF; snap_mxx <= '0; snap_mny <= 10'h3FF; snap_mxy <= '0;
      ext_min_x <= 10'h3FF; ext_max_x <= '0; ext_min_y <= 10'h3FF; ext_max_y <= '0;
`endif
    end else begin
      overrun <= frame_end && (state != IDLE);
      if (frame_end) begin
        cnt <= '0; sx <= '0; sy <= '0;
      end else begin
        cnt <= cnt_nx; sx <= sx_nx; sy <= sy_nx;
      end
`ifdef BOX_CENTROID_EXTENT_EN
      if (frame_end) begin
        run_min_x <= 10'h3FF; run_max_x <= '0; run_min_y <= 10'h3FF; run_max_y <= '0;
      end else begin
        run_min_x <= mnx_nx; run_max_x <= mxx_nx; run_min_y <= mny_nx; run_max_y <= mxy_nx;
      end
`endif
      case (state)
        IDLE: if (frame_end) begin
          if (found_nx) begin
            snap_cnt <= cnt_nx;
            snap_sy  <= sy_nx;
            dvd      <= sx_nx;
            rem      <= '0;
            step     <= '0;
`ifdef BOX_CENTROID_EXTENT_EN
            snap_mnx <= mnx_nx; snap_mxx <= mxx_nx; snap_mny <= mny_nx; snap_mxy <= mxy_nx;
`endif
          end else begin
            pix_count    <= cnt_nx;
            target_found <= 1'b0;
          end
        end
        DIV_X: begin
          dvd  <= dvd_next;
          rem  <= rem_next;
          step <= step + 1'b1;
          if (step == STEP_W'(ACC_W - 1)) begin
            quot_x <= dvd_next[9:0];
            step   <= '0;
          end
        end
        DIV_Y: begin
          if (step == '0) begin
            dvd  <= snap_sy;
            rem  <= '0;
            step <= STEP_W'(1);
          end else begin
            dvd  <= dvd_next;
            rem  <= rem_next;
            step <= step + 1'b1;
            if (step == STEP_W'(ACC_W)) begin
              centroid_x   <= quot_x;
              centroid_y   <= dvd_next[9:0];
              pix_count    <= snap_cnt;
              target_found <= 1'b1;
`ifdef BOX_CENTROID_EXTENT_EN
              ext_min_x <= snap_mnx; ext_max_x <= snap_mxx;
              ext_min_y <= snap_mny; ext_max_y <= snap_mxy;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
